spike_rr_arbiter_4: RTL and testbench

Clocked four-requester round-robin arbiter for spike packets. Its job is to merge the four per-neuron-cluster spike streams onto the single router/PE input link. It replaces random-choice arbitration with deterministic, starvation-free fair arbitration. It registers the winning packet and tags it with the 2-bit source index, so downstream logic can demultiplex weights and addresses.

---
 rtl/spike_rr_arbiter_4.sv | 131 +++++++++++++
 tb/tb_spike_rr_arbiter_4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rr_arbiter_4.sv
// Four-requester round-robin spike arbiter with a registered output stage tagged by source index.
// Optional burst mode (consecutive grants to one owner) is enabled by defining SPIKE_ARB_BURST_EN.
module spike_rr_arbiter_4 #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_src,
    input  logic               out_ready
);

    if (BURST < 1 || BURST > 15) begin : g_burst_range
        $error("spike_rr_arbiter_4: BURST must be in 1..15");
    end

    logic             load;
    logic             any_valid;
    logic             accept;
    logic [1:0]       winner;
    logic [WIDTH-1:0] req_data [4];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_src_q, out_src_d;
    logic [1:0]       ptr_q, ptr_d;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the farthest slot back to ptr so the nearest valid requester is the last to overwrite.
    always_comb begin
        winner = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
    end

    assign any_valid = |in_valid;
    assign load      = !out_valid_q || out_ready;
    assign accept    = load && any_valid;
    // Gated by rst_n so no requester sees a grant while the arbiter is held in reset.
    assign in_ready  = (accept && rst_n) ? (4'b0001 << winner) : 4'b0000;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[winner];
            out_src_d   = winner;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef SPIKE_ARB_BURST_EN
    logic [3:0] bcnt_q, bcnt_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] run;

    always_comb begin
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        owner_d = owner_q;
        run     = (winner == owner_q && bcnt_q != 4'd0) ? bcnt_q + 4'd1 : 4'd1;
        if (accept) begin
            owner_d = winner;
            if (run >= 4'(BURST)) begin
                ptr_d  = winner + 2'd1;
                bcnt_d = 4'd1;
            end else begin
                ptr_d  = winner;
                bcnt_d = run;
            end
        end else if (bcnt_q != 4'd0 && !in_valid[owner_q]) begin
            // Owner gave up its slot: a later request from it starts a fresh run.
            bcnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= 4'd0;
            owner_q <= 2'd0;
        end else begin
            bcnt_q  <= bcnt_d;
            owner_q <= owner_d;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = winner + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            ptr_q       <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_spike_rr_arbiter_4.sv
// Self-checking bench for spike_rr_arbiter_4: directed vector table, reset/burst sequences
// and randomized traffic compared against a behavioural round-robin model.
module tb_spike_rr_arbiter_4;

    localparam int WIDTH = 32;
`ifdef SPIKE_ARB_BURST_EN
    localparam int DUT_BURST = 3;
    localparam int M_BURST   = 3;
`else
    localparam int DUT_BURST = 4;
    localparam int M_BURST   = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_src;
    logic               out_ready;

    spike_rr_arbiter_4 #(.WIDTH(WIDTH), .BURST(DUT_BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: pointer, output register image, and current run of grants to one source.
    int               m_ptr, m_os, m_last, m_run;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_src;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] pattern(input int i);
        return WIDTH'(32'h1111_1111 * (i + 1));
    endfunction

    function automatic int m_winner(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready(input logic [3:0] v, input logic ordy);
        logic [3:0] r;
        int w;
        r = 4'b0000;
        w = m_winner(v);
        if ((!m_ov || ordy) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_os = 0; m_last = 0; m_run = 0; m_ov = 1'b0; m_od = '0;
    endtask

    task automatic m_edge(input logic [3:0] v, input logic ordy);
        int w;
        w = m_winner(v);
        if ((!m_ov || ordy) && w >= 0) begin
            m_od = in_data[w*WIDTH +: WIDTH];
            m_os = w;
            m_ov = 1'b1;
            m_run = (w == m_last && m_run > 0) ? m_run + 1 : 1;
            m_last = w;
            if (m_run >= M_BURST) begin
                m_ptr = (w + 1) % 4;
                m_run = 1;
            end else begin
                m_ptr = w;
            end
        end else begin
            if (ordy) m_ov = 1'b0;
            if (m_run > 0 && !v[m_last]) m_run = 0;
        end
    endtask

    // One clock: drive, check combinational in_ready, clock, check registered outputs.
    task automatic cycle(input logic [3:0] v, input logic ordy, output logic [3:0] got_ready,
                         output logic [3:0] exp_ready);
        in_valid  = v;
        out_ready = ordy;
        #1;
        exp_ready = m_ready(v, ordy);
        got_ready = in_ready;
        check("in_ready", in_ready, WIDTH'(exp_ready));
        @(posedge clk);
        m_edge(v, ordy);
        #1;
        check("out_valid", WIDTH'(out_valid), WIDTH'(m_ov));
        check("out_src", WIDTH'(out_src), WIDTH'(m_os));
        check("out_data", out_data, m_od);
    endtask

    task automatic do_reset();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic load_patterns();
        for (int i = 0; i < 4; i++) in_data[i*WIDTH +: WIDTH] = pattern(i);
    endtask

    task automatic add_vec(input logic [3:0] v, input logic o, input logic [3:0] r,
                           input logic ov, input logic [1:0] s);
        vec_t e;
        e.valid = v; e.ordy = o; e.exp_ready = r; e.exp_ov = ov; e.exp_src = s;
        vecs.push_back(e);
    endtask

    initial begin
        logic [3:0] got_r, exp_r;
        logic [3:0] pend;

        rst_n = 1'b0;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        in_data = '0;
        #1;
        check("reset in_ready", WIDTH'(in_ready), '0);
        do_reset();
        check("reset out_valid", WIDTH'(out_valid), '0);
        check("reset out_src", WIDTH'(out_src), '0);
        check("reset out_data", out_data, '0);
        load_patterns();

`ifndef SPIKE_ARB_BURST_EN
        // Fairness, skip/wrap from ptr=2, drain, ptr=3 proof, backpressure, back-to-back resume.
        for (int i = 0; i < 5; i++) add_vec(4'b1111, 1'b1, 4'b0001 << (i % 4), 1'b1, 2'(i % 4));
        add_vec(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
        add_vec(4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3);
        add_vec(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
        add_vec(4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3);
        add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);
        add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3);
        add_vec(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2);
        add_vec(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3);
        for (int i = 0; i < 5; i++) add_vec(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
        add_vec(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);

        foreach (vecs[i]) begin
            cycle(vecs[i].valid, vecs[i].ordy, got_r, exp_r);
            check($sformatf("vec%0d in_ready", i), WIDTH'(got_r), WIDTH'(vecs[i].exp_ready));
            check($sformatf("vec%0d out_valid", i), WIDTH'(out_valid), WIDTH'(vecs[i].exp_ov));
            check($sformatf("vec%0d out_src", i), WIDTH'(out_src), WIDTH'(vecs[i].exp_src));
            if (vecs[i].exp_ov) check($sformatf("vec%0d out_data", i), out_data, pattern(int'(vecs[i].exp_src)));
        end
`else
        begin
            int exp_seq[8] = '{0, 0, 0, 1, 1, 1, 0, 1};
            for (int i = 0; i < 8; i++) begin
                cycle((i < 7) ? 4'b0011 : 4'b0010, 1'b1, got_r, exp_r);
                check($sformatf("burst%0d out_src", i), WIDTH'(out_src), WIDTH'(exp_seq[i]));
                check($sformatf("burst%0d out_data", i), out_data, pattern(exp_seq[i]));
            end
        end
`endif

        // Asynchronous reset while a packet sits in the output register.
        cycle(4'b1111, 1'b1, got_r, exp_r);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", WIDTH'(out_valid), '0);
        check("midreset out_data", out_data, '0);
        check("midreset out_src", WIDTH'(out_src), '0);
        check("midreset in_ready", WIDTH'(in_ready), '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        cycle(4'b1111, 1'b1, got_r, exp_r);
        check("post-reset grant", WIDTH'(out_src), '0);
        check("post-reset valid", WIDTH'(out_valid), 1);

        // Randomized traffic: requesters hold valid and data until their transfer.
        do_reset();
        pend = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            logic ordy;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            cycle(pend, ordy, got_r, exp_r);
            pend = pend & ~exp_r;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
